// File: rtl/reply_router.sv
// Return-path router: snoops forward transfers to learn per-destination return tags and
// round-robins pending 4-bit replies onto one valid/ready channel. Optional: REPLY_TIMEOUT_EN.
module reply_router #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fwd_valid,
    input  logic [1:0]  fwd_src,
    input  logic [1:0]  fwd_dst,
    input  logic [3:0]  rsp_req,
    input  logic [15:0] rsp_data,
    output logic [3:0]  rsp_ack,
    output logic        ret_valid,
    input  logic        ret_ready,
    output logic [3:0]  ret_data,
    output logic [1:0]  ret_src,
    output logic [1:0]  ret_dst,
    output logic [1:0]  err
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t          state, state_next;
    logic [3:0]      pending;
    logic [3:0][1:0] tag;
    logic [1:0]      rr;
    logic [1:0]      win;
    logic [3:0]      elig;
    logic            any_elig;
    logic            err_orphan;
    logic            err_timeout;

    if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
        $error("reply_router: TIMEOUT must be in 1..15");
    end

    assign elig = rsp_req & pending;

    always_comb begin
        win      = '0;
        any_elig = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (!any_elig && elig[rr + 2'(k)]) begin
                any_elig = 1'b1;
                win      = rr + 2'(k);
            end
        end
    end

`ifdef REPLY_TIMEOUT_EN
    logic [3:0] cnt;
    logic       timed_out;
`endif

    always_comb begin
        state_next = state;
`ifdef REPLY_TIMEOUT_EN
        timed_out  = 1'b0;
`endif
        case (state)
            IDLE: if (any_elig) state_next = SEND;
            SEND: begin
                if (ret_ready) begin
                    state_next = DONE;
`ifdef REPLY_TIMEOUT_EN
                end else if (cnt == 4'(TIMEOUT - 1)) begin
                    // count reaches TIMEOUT on this cycle; a handshake here takes priority
                    state_next = DONE;
                    timed_out  = 1'b1;
`endif
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            tag        <= '0;
            rr         <= '0;
            ret_data   <= '0;
            ret_src    <= '0;
            ret_dst    <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (state == IDLE && any_elig) begin
                ret_data <= rsp_data[{win, 2'b00} +: 4];
                ret_src  <= tag[win];
                ret_dst  <= win;
            end
            if (state == DONE) begin
                pending[ret_dst] <= 1'b0;
                rr               <= ret_dst + 2'd1;
            end
            // later assignment lets a same-cycle capture win over the DONE clear
            if (fwd_valid) begin
                pending[fwd_dst] <= 1'b1;
                tag[fwd_dst]     <= fwd_src;
            end
            if (|(rsp_req & ~pending)) err_orphan <= 1'b1;
        end
    end

`ifdef REPLY_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state != SEND) cnt <= '0;
            else               cnt <= cnt + 4'd1;
            if (timed_out) err_timeout <= 1'b1;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        rsp_ack = '0;
        if (state == DONE) rsp_ack[ret_dst] = 1'b1;
    end

    assign ret_valid = (state == SEND);
    assign err       = {err_timeout, err_orphan};

endmodule

// File: tb/tb_reply_router.sv
// Directed bench for reply_router: stimulus pushes expected replies into a scoreboard
// queue; a monitor pops and compares on every return-channel handshake.
module tb_reply_router;
    logic        clk;
    logic        rst_n;
    logic        fwd_valid;
    logic [1:0]  fwd_src;
    logic [1:0]  fwd_dst;
    logic [3:0]  rsp_req;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_ack;
    logic        ret_valid;
    logic        ret_ready;
    logic [3:0]  ret_data;
    logic [1:0]  ret_src;
    logic [1:0]  ret_dst;
    logic [1:0]  err;

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] src;
        logic [1:0] dst;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;
    logic       ack_due;
    logic [3:0] ack_exp;

    reply_router #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fwd_valid (fwd_valid),
        .fwd_src   (fwd_src),
        .fwd_dst   (fwd_dst),
        .rsp_req   (rsp_req),
        .rsp_data  (rsp_data),
        .rsp_ack   (rsp_ack),
        .ret_valid (ret_valid),
        .ret_ready (ret_ready),
        .ret_data  (ret_data),
        .ret_src   (ret_src),
        .ret_dst   (ret_dst),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares each handshake against the scoreboard and the ack that follows it.
    initial begin
        ack_due = 1'b0;
        ack_exp = '0;
        forever begin
            @(negedge clk);
            if (ack_due) begin
                check("ack_after_hs", rsp_ack, ack_exp);
                ack_due = 1'b0;
            end
            if (rst_n && ret_valid && ret_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_reply: got data=%0h src=%0h dst=%0h want none",
                             ret_data, ret_src, ret_dst);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ret_data", ret_data, e.data);
                    check("ret_src",  ret_src,  e.src);
                    check("ret_dst",  ret_dst,  e.dst);
                    ack_exp = 4'b0001 << e.dst;
                    ack_due = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic do_reset();
        rst_n     = 1'b0;
        fwd_valid = 1'b0;
        fwd_src   = '0;
        fwd_dst   = '0;
        rsp_req   = '0;
        rsp_data  = '0;
        ret_ready = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_outputs", {ret_valid, ret_data, ret_src, ret_dst, rsp_ack, err}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic fwd(input logic [1:0] src, input logic [1:0] dst);
        fwd_valid = 1'b1;
        fwd_src   = src;
        fwd_dst   = dst;
        @(posedge clk);
        #1 fwd_valid = 1'b0;
    endtask

    task automatic wait_ack(input int d);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_ack != 4'b0) begin
                check("ack_dst", rsp_ack, 4'b0001 << d);
                rsp_req[d] = 1'b0;
                got = 1'b1;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ack_wait: got no ack want ack for dst %0d within 20 cycles", d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // basic route, then the same request again must be treated as orphan
        do_reset();
        fwd(2'd2, 2'd1);
        rsp_req   = 4'b0010;
        rsp_data  = 16'h00A0;
        ret_ready = 1'b1;
        sb.push_back('{data: 4'hA, src: 2'd2, dst: 2'd1});
        wait_ack(1);
        rsp_req = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("cleared_no_valid", ret_valid, 1'b0);
        end
        check("cleared_err", err, 2'b01);

        // round robin over all four, one ret_valid per three cycles
        do_reset();
        fwd(2'd3, 2'd0);
        fwd(2'd2, 2'd1);
        fwd(2'd1, 2'd2);
        fwd(2'd0, 2'd3);
        rsp_req   = 4'b1111;
        rsp_data  = 16'hD5B7;
        ret_ready = 1'b1;
        sb.push_back('{data: 4'h7, src: 2'd3, dst: 2'd0});
        sb.push_back('{data: 4'hB, src: 2'd2, dst: 2'd1});
        sb.push_back('{data: 4'h5, src: 2'd1, dst: 2'd2});
        sb.push_back('{data: 4'hD, src: 2'd0, dst: 2'd3});
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("rr_valid_pattern", ret_valid, (i % 3) == 1);
            check("rr_ack_pattern", rsp_ack, ((i % 3) == 2) ? (4'b0001 << (i / 3)) : 4'b0000);
            rsp_req = rsp_req & ~rsp_ack;
        end
        @(posedge clk);
        #1;
        fwd(2'd1, 2'd0);
        fwd(2'd3, 2'd2);
        rsp_req  = 4'b0101;
        rsp_data = 16'h0E0C;
        sb.push_back('{data: 4'hC, src: 2'd1, dst: 2'd0});
        sb.push_back('{data: 4'hE, src: 2'd3, dst: 2'd2});
        wait_ack(0);
        wait_ack(2);
        check("rr_err", err, 2'b00);

        // backpressure with changing data and a forward to the destination in SEND
        do_reset();
        fwd(2'd0, 2'd3);
        ret_ready = 1'b0;
        rsp_req   = 4'b1000;
        rsp_data  = 16'h9000;
        sb.push_back('{data: 4'h9, src: 2'd0, dst: 2'd3});
        @(negedge clk);
        check("bp_idle_valid", ret_valid, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 rsp_data = 16'($urandom);
            if (i == 3) begin
                fwd_valid = 1'b1;
                fwd_src   = 2'd2;
                fwd_dst   = 2'd3;
            end else begin
                fwd_valid = 1'b0;
            end
            @(negedge clk);
            check("bp_valid", ret_valid, 1'b1);
            check("bp_data",  ret_data,  4'h9);
            check("bp_src",   ret_src,   2'd0);
            check("bp_no_ack", rsp_ack,  4'b0000);
        end
        @(posedge clk);
        #1 ret_ready = 1'b1;
        wait_ack(3);

        // orphan request
        do_reset();
        rsp_req  = 4'b1000;
        rsp_data = 16'h6000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("orphan_no_valid", ret_valid, 1'b0);
            check("orphan_no_ack",   rsp_ack,   4'b0000);
        end
        check("orphan_err", err, 2'b01);
        @(posedge clk);
        #1;
        fwd(2'd1, 2'd3);
        ret_ready = 1'b1;
        sb.push_back('{data: 4'h6, src: 2'd1, dst: 2'd3});
        wait_ack(3);
        check("orphan_err_sticky", err, 2'b01);

        // forward capture on the DONE cycle of the same destination
        do_reset();
        fwd(2'd0, 2'd0);
        rsp_req   = 4'b0001;
        rsp_data  = 16'h0001;
        ret_ready = 1'b1;
        sb.push_back('{data: 4'h1, src: 2'd0, dst: 2'd0});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 fwd_valid = 1'b1;
        fwd_src   = 2'd3;
        fwd_dst   = 2'd0;
        @(negedge clk);
        check("coll_done_ack", rsp_ack, 4'b0001);
        rsp_req = 4'b0000;
        @(posedge clk);
        #1 fwd_valid = 1'b0;
        rsp_data = 16'h0005;
        rsp_req  = 4'b0001;
        sb.push_back('{data: 4'h5, src: 2'd3, dst: 2'd0});
        wait_ack(0);
        check("coll_err", err, 2'b00);

        // asynchronous reset in the middle of SEND
        do_reset();
        fwd(2'd2, 2'd2);
        ret_ready = 1'b0;
        rsp_req   = 4'b0100;
        rsp_data  = 16'h0F00;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_send_valid", {ret_valid, ret_data, ret_src, ret_dst}, {1'b1, 4'hF, 2'd2, 2'd2});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {ret_valid, ret_data, ret_src, ret_dst, rsp_ack, err}, 32'h0);
        sb.delete();
        rsp_req = 4'b0000;
        repeat (2) begin
            @(negedge clk);
            check("reset_no_ack", rsp_ack, 4'b0000);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_valid", ret_valid, 1'b0);
        @(posedge clk);
        #1;

        // no ready: timeout drop when enabled, indefinite wait otherwise
        do_reset();
        fwd(2'd1, 2'd1);
        ret_ready = 1'b0;
        rsp_req   = 4'b0010;
        rsp_data  = 16'h0030;
        @(negedge clk);
`ifdef REPLY_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("to_valid", ret_valid, 1'b1);
            check("to_no_ack", rsp_ack, 4'b0000);
        end
        @(negedge clk);
        check("to_ack", rsp_ack, 4'b0010);
        check("to_valid_drop", ret_valid, 1'b0);
        check("to_err", err, 2'b10);
        rsp_req = 4'b0000;
        @(posedge clk);
        #1;
`else
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("wait_valid", ret_valid, 1'b1);
            check("wait_no_ack", rsp_ack, 4'b0000);
        end
        check("wait_err", err, 2'b00);
        sb.push_back('{data: 4'h3, src: 2'd1, dst: 2'd1});
        @(posedge clk);
        #1 ret_ready = 1'b1;
        wait_ack(1);
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
